// File: rtl/p09_level_loader.sv
// Level loader: fetches NUM_ROWS block rows and streams them to the game as 16-bit SPI mode-0 words.
// Optional miso readback into state_out is enabled by defining P09_LEVEL_LOADER_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for start, ss high
// STOP   | sending the stop-game word
// FETCH  | row_req high, waiting for row_valid (sck held low)
// WRITE  | sending the write-line word for the fetched row
// SHIFT  | sending the shift-line word
// GAP    | 2*CLK_DIV idle cycles after a word, ss still low
// FINISH | ss high, then one-cycle done pulse before IDLE
module p09_level_loader #(
  parameter int NUM_ROWS   = 15,
  parameter int CLK_DIV    = 4,
  parameter int STATE_SIZE = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop_game,
  output logic                  busy,
  output logic                  done,
  output logic                  row_req,
  input  logic                  row_valid,
  input  logic [12:0]           row_data,
  output logic                  sck,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso,
  output logic [STATE_SIZE-1:0] state_out,
  output logic                  state_valid
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int TW = 9;
  localparam logic [TW-1:0] PHASE_LD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(2 * CLK_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
  localparam logic [2:0]    OP_WRITE = 3'b001;
  localparam logic [2:0]    OP_SHIFT = 3'b010;
  localparam logic [2:0]    OP_STOP  = 3'b011;

  typedef enum logic [2:0] {IDLE, STOP, FETCH, WRITE, SHIFT, GAP, FINISH} state_t;

  state_t        state, state_nxt;
  state_t        last_word, last_word_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [3:0]    bit_idx, bit_idx_nxt;
  logic [15:0]   tx_word, tx_word_nxt;
  logic [RW-1:0] row_cnt, row_cnt_nxt;
  logic          sck_nxt, ss_nxt, mosi_nxt, busy_nxt, done_nxt, row_req_nxt;
  logic          load_word;
  logic [15:0]   load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_word <= IDLE;
      tmr       <= '0;
      bit_idx   <= '0;
      tx_word   <= '0;
      row_cnt   <= '0;
      sck       <= 1'b0;
      ss        <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_req   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_word <= last_word_nxt;
      tmr       <= tmr_nxt;
      bit_idx   <= bit_idx_nxt;
      tx_word   <= tx_word_nxt;
      row_cnt   <= row_cnt_nxt;
      sck       <= sck_nxt;
      ss        <= ss_nxt;
      mosi      <= mosi_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      row_req   <= row_req_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_word_nxt = last_word;
    tmr_nxt       = tmr;
    bit_idx_nxt   = bit_idx;
    tx_word_nxt   = tx_word;
    row_cnt_nxt   = row_cnt;
    sck_nxt       = sck;
    ss_nxt        = ss;
    mosi_nxt      = mosi;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    row_req_nxt   = 1'b0;
    load_word     = 1'b0;
    load_val      = 16'h0000;

    unique case (state)
      IDLE: begin
        if (start) begin
          busy_nxt    = 1'b1;
          ss_nxt      = 1'b0;
          row_cnt_nxt = '0;
          if (stop_game) begin
            state_nxt = STOP;
            load_word = 1'b1;
            load_val  = {OP_STOP, 13'h0000};
          end else begin
            state_nxt   = FETCH;
            row_req_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        if (row_valid) begin
          state_nxt = WRITE;
          load_word = 1'b1;
          load_val  = {OP_WRITE, row_data};
        end else begin
          row_req_nxt = 1'b1;
        end
      end
      // Each bit: CLK_DIV cycles low (mosi settles), then CLK_DIV cycles high.
      STOP, WRITE, SHIFT: begin
        if (tmr != '0) begin
          tmr_nxt = tmr - 1'b1;
        end else if (!sck) begin
          sck_nxt = 1'b1;
          tmr_nxt = PHASE_LD;
        end else if (bit_idx == 4'd0) begin
          sck_nxt       = 1'b0;
          mosi_nxt      = 1'b0;
          tmr_nxt       = GAP_LD;
          last_word_nxt = state;
          state_nxt     = GAP;
        end else begin
          sck_nxt     = 1'b0;
          bit_idx_nxt = bit_idx - 4'd1;
          mosi_nxt    = tx_word[bit_idx - 4'd1];
          tmr_nxt     = PHASE_LD;
        end
      end
      GAP: begin
        if (tmr != '0) begin
          tmr_nxt = tmr - 1'b1;
        end else if (last_word == WRITE) begin
          state_nxt = SHIFT;
          load_word = 1'b1;
          load_val  = {OP_SHIFT, 13'h0000};
        end else if (last_word == STOP) begin
          state_nxt   = FETCH;
          row_req_nxt = 1'b1;
        end else if (row_cnt == ROW_LAST) begin
          state_nxt = FINISH;
          ss_nxt    = 1'b1;
        end else begin
          row_cnt_nxt = row_cnt + 1'b1;
          state_nxt   = FETCH;
          row_req_nxt = 1'b1;
        end
      end
      // First FINISH cycle raises done; the second returns to IDLE, so start never meets done.
      FINISH: begin
        if (!done) begin
          done_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (load_word) begin
      tx_word_nxt = load_val;
      bit_idx_nxt = 4'd15;
      mosi_nxt    = load_val[15];
      sck_nxt     = 1'b0;
      tmr_nxt     = PHASE_LD;
    end
  end

`ifdef P09_LEVEL_LOADER_READBACK_EN
  localparam int CW = $clog2(STATE_SIZE + 1);

  logic [CW-1:0] cap_cnt;
  logic          sck_rise;
  logic          start_ok;

  assign sck_rise = sck_nxt & ~sck;
  assign start_ok = (state == IDLE) & start;

  // miso is sampled on the clk edge that drives sck high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_out   <= '0;
      state_valid <= 1'b0;
      cap_cnt     <= '0;
    end else if (start_ok) begin
      state_out   <= '0;
      state_valid <= 1'b0;
      cap_cnt     <= '0;
    end else begin
      if (sck_rise && (cap_cnt != CW'(STATE_SIZE))) begin
        state_out <= {state_out[STATE_SIZE-2:0], miso};
        cap_cnt   <= cap_cnt + 1'b1;
      end
      if (done_nxt) begin
        state_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_miso;

  assign unused_miso = miso;
  assign state_out   = '0;
  assign state_valid = 1'b0;
`endif

endmodule

// File: doc/p09_level_loader.md
P09_LEVEL_LOADER -- requirements
Module: p09_level_loader

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 15, number of block rows streamed per load.
REQ-002 SHALL have parameter CLK_DIV, default 4, sck half-period in clk cycles; legal range 2..255.
REQ-003 SHALL have parameter STATE_SIZE, default 21, number of miso bits captured per load.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port stop_game  input  1  when sampled high with start, a stop word is sent first.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-010 SHALL have port row_req  output  1  requests the next 13-bit row pattern.
REQ-011 SHALL have port row_valid  input  1  row_data valid; accepted only while row_req is high.
REQ-012 SHALL have port row_data  input  13  block-line pattern, bit 12 = leftmost block.
REQ-013 SHALL have ports sck, ss, mosi  output  1 each  SPI master to game SPI slave; ss active-low.
REQ-014 SHALL have port miso  input  1  serial state readback from game.
REQ-015 SHALL have port state_out  output  STATE_SIZE  captured game state, first received bit in MSB.
REQ-016 SHALL have port state_valid  output  1  high once state_out holds a complete capture.

Function
REQ-017 SHALL use SPI mode 0, MSB first, 16-bit words; mosi changes only while sck low; sck high and low phases each CLK_DIV cycles.
REQ-018 SHALL encode words as {opcode[2:0], payload[12:0]}: 3'b001 write line (payload=row_data), 3'b010 shift line (payload 0), 3'b011 stop game (payload 0).
REQ-019 SHALL implement states IDLE, STOP, FETCH, WRITE, SHIFT, GAP, FINISH.
REQ-020 SHALL in IDLE accept start; ss falls on the next cycle; first sck rise occurs CLK_DIV cycles after ss falls.
REQ-021 SHALL send STOP only if stop_game was high in the start cycle, then go to FETCH.
REQ-022 SHALL for rows 0..NUM_ROWS-1: FETCH (row_req high until row_valid), WRITE word, SHIFT word.
REQ-023 SHALL hold sck low and ss low while stalled in FETCH; row_req drops the cycle after row_valid is accepted.
REQ-024 SHALL insert GAP of 2*CLK_DIV cycles (sck low, ss low) after every word.
REQ-025 SHALL after the last SHIFT word's GAP raise ss, enter FINISH, pulse done one cycle later, then return to IDLE.
REQ-026 SHALL ignore start while busy; start and done in the same cycle are not possible (done precedes IDLE).
REQ-027 SHALL ignore row_valid when row_req is low.
REQ-028 SHALL use a row counter wide enough for NUM_ROWS, terminating exactly at NUM_ROWS-1 with no wrap.
REQ-029 SHALL keep mosi at 0 whenever ss is high.

Reset
REQ-030 SHALL on rst: state IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, row_req=0, state_valid=0, state_out=0, counters 0.
REQ-031 SHALL, on rst asserted mid-load, abort in the same edge with the reset values above; no partial done.

Configuration
REQ-032 SHALL gate readback with macro P09_LEVEL_LOADER_READBACK_EN.
REQ-033 SHALL with P09_LEVEL_LOADER_READBACK_EN defined sample miso on each sck rising-edge cycle, shift the first STATE_SIZE bits of a load into state_out, set state_valid with done and clear it on the next accepted start.
REQ-034 SHALL with P09_LEVEL_LOADER_READBACK_EN undefined tie state_out to 0 and state_valid to 0 and contain no capture logic.

Verification
REQ-035 Default params, start, stop_game=0, row_valid same cycle as row_req, row_data=13'h1FFF -> 30 words, each write word 16'h3FFF, each shift word 16'h4000, done once, ss low throughout.
REQ-036 start with stop_game=1 -> first word 16'h6000, then 30 load words; total 31 words.
REQ-037 Hold row_valid low 50 cycles during row 3 FETCH -> sck stays low, ss stays low, no bit lost, word content unchanged.
REQ-038 start pulsed again at bit 5 of word 2 -> ignored; exactly one done; word count 30.
REQ-039 rst asserted at bit 9 of word 4 -> next cycle ss=1, sck=0, mosi=0, busy=0; new start gives a clean full load.
REQ-040 READBACK_EN defined, miso driven with 21'h15A5A5 MSB first -> after done state_out=21'h15A5A5, state_valid=1; undefined -> both 0.
